// File: rtl/dacrpt_fifo_pkg.sv
// Shared field layout for the DAC result-reader FIFO: RPTCTL bits, RPTSTA fields,
// HI-byte packing and the effective-threshold helper.
package dacrpt_fifo_pkg;

   localparam int CTL_EN     = 0;
   localparam int CTL_CLR    = 1;
   localparam int CTL_IEN    = 2;
   localparam int CTL_THR_LO = 3;
   localparam int CTL_THR_HI = 5;
   localparam int CTL_OVFC   = 7;

   localparam int STA_OVF    = 7;
   localparam int STA_EMPTY  = 6;
   localparam int STA_FULL   = 5;
   localparam int STA_IEN    = 4;
   localparam int STA_CNT_HI = 3;
   localparam int STA_CNT_LO = 0;

   localparam int HI_CH_HI   = 7;
   localparam int HI_CH_LO   = 4;
   localparam int HI_MSB_HI  = 1;
   localparam int HI_MSB_LO  = 0;

   // A threshold of 0 behaves as 1 and anything past the FIFO depth saturates.
   function automatic logic [3:0] thr_eff(input logic [2:0] thr, input logic [3:0] depth);
      logic [3:0] t;
      t = {1'b0, thr};
      if (t == 4'd0) begin
         t = 4'd1;
      end else if (t > depth) begin
         t = depth;
      end else begin
         t = t;
      end
      return t;
   endfunction

endpackage

// File: rtl/dacrpt_fifo_rptq.sv
// Generic synchronous register-array FIFO with push, pop, clear and occupancy count.
module dacrpt_fifo_rptq
   import dacrpt_fifo_pkg::*;
#(
   parameter int W       = 14,
   parameter int DEPTH   = 4,
   parameter int BIT_CNT = 4
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_clr,
   input  logic [W-1:0]       i_wdata,
   output logic [W-1:0]       o_rdata,
   output logic               o_full,
   output logic               o_empty,
   output logic [BIT_CNT-1:0] o_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]       r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [BIT_CNT-1:0] r_cnt;
   logic               w_push_ok;
   logic               w_pop_ok;

   // A pop on an empty queue is dropped; a push on a full queue needs a same-cycle pop.
   always_comb begin
      w_pop_ok  = i_pop & ~o_empty;
      w_push_ok = i_push & (~o_full | w_pop_ok);
   end

   // Pointer, count and storage update; clear outranks push and pop.
   always_ff @(posedge clk) begin
      if (srst || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + BIT_CNT'(1);
            2'b01:   r_cnt <= r_cnt - BIT_CNT'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_cnt   = r_cnt;
   assign o_full  = (r_cnt == BIT_CNT'(DEPTH));
   assign o_empty = (r_cnt == BIT_CNT'(0));

endmodule

// File: rtl/dacrpt_fifo.sv
// DAC/SAR result reader: captures tagged conversion reports into a small FIFO,
// exposes them through RPTHI/RPTLO and raises a threshold/overflow interrupt.
module dacrpt_fifo
   import dacrpt_fifo_pkg::*;
#(
   parameter int BIT_PTR = 4,
   parameter int DEPTH   = 4,
   parameter int BIT_CNT = 4
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               rpt_upd,
   input  logic [BIT_PTR-1:0] rpt_ch,
   input  logic [9:0]         rpt_v,
   input  logic [7:0]         r_wdat,
   input  logic [1:0]         r_wr,
   input  logic               r_rd_lo,
   output logic [7:0]         o_rpt_hi,
   output logic [7:0]         o_rpt_lo,
   output logic [7:0]         o_rptsta,
   output logic [7:0]         o_rptmsk,
   output logic               o_intr
);

   logic               r_en;
   logic               r_ien;
   logic [2:0]         r_thr;
   logic [7:0]         r_msk;
   logic               r_ovf;

   logic               w_ctl_wr;
   logic               w_clr;
   logic               w_ch_ok;
   logic               w_push_req;
   logic               w_full;
   logic               w_empty;
   logic [BIT_CNT-1:0] w_cnt;
   logic [BIT_CNT-1:0] w_thr_eff;
   logic [BIT_PTR+9:0] w_head;
   logic               w_unused;

   assign w_ctl_wr   = r_wr[0];
   assign w_clr      = w_ctl_wr & r_wdat[CTL_CLR];
   assign w_ch_ok    = (rpt_ch >= BIT_PTR'(8)) | r_msk[rpt_ch[2:0]];
   assign w_push_req = rpt_upd & r_en & w_ch_ok;
   assign w_unused   = r_wdat[6];

   dacrpt_fifo_rptq #(
      .W       (BIT_PTR + 10),
      .DEPTH   (DEPTH),
      .BIT_CNT (BIT_CNT)
   ) u_rptq (
      .clk     (clk),
      .srst    (srst),
      .i_push  (w_push_req),
      .i_pop   (r_rd_lo),
      .i_clr   (w_clr),
      .i_wdata ({rpt_ch, rpt_v}),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_cnt   (w_cnt)
   );

   // Control and mask registers; clr itself is never stored.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_en  <= 1'b0;
         r_ien <= 1'b0;
         r_thr <= 3'd0;
         r_msk <= 8'hFF;
      end else begin
         if (w_ctl_wr) begin
            r_en  <= r_wdat[CTL_EN];
            r_ien <= r_wdat[CTL_IEN];
            r_thr <= r_wdat[CTL_THR_HI:CTL_THR_LO];
         end else begin
            r_en  <= r_en;
            r_ien <= r_ien;
            r_thr <= r_thr;
         end
         if (r_wr[1]) begin
            r_msk <= r_wdat;
         end else begin
            r_msk <= r_msk;
         end
      end
   end

   // Sticky overflow: only a dropped push sets it, a pop in the same cycle makes room.
   always_ff @(posedge clk) begin
      if (srst || w_clr) begin
         r_ovf <= 1'b0;
      end else if (w_push_req && w_full && !r_rd_lo) begin
         r_ovf <= 1'b1;
      end else if (w_ctl_wr && r_wdat[CTL_OVFC]) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign w_thr_eff = BIT_CNT'(thr_eff(r_thr, 4'(DEPTH)));

   // Byte formatting; an empty queue reads as zero rather than a stale entry.
   always_comb begin
      o_rpt_hi = 8'h00;
      o_rpt_lo = 8'h00;
      if (!w_empty) begin
         o_rpt_hi[HI_CH_HI:HI_CH_LO]   = w_head[13:10];
         o_rpt_hi[HI_MSB_HI:HI_MSB_LO] = w_head[9:8];
         o_rpt_lo                      = w_head[7:0];
      end else begin
         o_rpt_hi = 8'h00;
         o_rpt_lo = 8'h00;
      end
   end

   assign o_rptsta[STA_OVF]                 = r_ovf;
   assign o_rptsta[STA_EMPTY]               = w_empty;
   assign o_rptsta[STA_FULL]                = w_full;
   assign o_rptsta[STA_IEN]                 = r_ien;
   assign o_rptsta[STA_CNT_HI:STA_CNT_LO]   = w_cnt[3:0];
   assign o_rptmsk                          = r_msk;
   assign o_intr                            = r_ien & (r_ovf | (w_cnt >= w_thr_eff));

endmodule

// File: tb/tb_dacrpt_fifo.sv
// Directed bench for dacrpt_fifo with hand-computed expected register values.
module tb_dacrpt_fifo;

   logic       clk = 1'b0;
   logic       srst = 1'b0;
   logic       rpt_upd = 1'b0;
   logic [3:0] rpt_ch = 4'd0;
   logic [9:0] rpt_v = 10'd0;
   logic [7:0] r_wdat = 8'h00;
   logic [1:0] r_wr = 2'b00;
   logic       r_rd_lo = 1'b0;
   logic [7:0] o_rpt_hi;
   logic [7:0] o_rpt_lo;
   logic [7:0] o_rptsta;
   logic [7:0] o_rptmsk;
   logic       o_intr;

   int n_tests = 0;
   int n_fail  = 0;

   dacrpt_fifo #(.BIT_PTR(4), .DEPTH(4), .BIT_CNT(4)) dut (
      .clk      (clk),
      .srst     (srst),
      .rpt_upd  (rpt_upd),
      .rpt_ch   (rpt_ch),
      .rpt_v    (rpt_v),
      .r_wdat   (r_wdat),
      .r_wr     (r_wr),
      .r_rd_lo  (r_rd_lo),
      .o_rpt_hi (o_rpt_hi),
      .o_rpt_lo (o_rpt_lo),
      .o_rptsta (o_rptsta),
      .o_rptmsk (o_rptmsk),
      .o_intr   (o_intr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance one clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl_wr(input logic [7:0] v);
      r_wdat = v; r_wr = 2'b01;
      step();
      r_wr = 2'b00;
   endtask

   task automatic msk_wr(input logic [7:0] v);
      r_wdat = v; r_wr = 2'b10;
      step();
      r_wr = 2'b00;
   endtask

   task automatic push(input logic [3:0] ch, input logic [9:0] v);
      rpt_upd = 1'b1; rpt_ch = ch; rpt_v = v;
      step();
      rpt_upd = 1'b0;
   endtask

   task automatic pop();
      r_rd_lo = 1'b1;
      step();
      r_rd_lo = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_hi"},   {24'd0, o_rpt_hi}, 32'h00);
      chk({tag, "_lo"},   {24'd0, o_rpt_lo}, 32'h00);
      chk({tag, "_sta"},  {24'd0, o_rptsta}, 32'h40);
      chk({tag, "_msk"},  {24'd0, o_rptmsk}, 32'hFF);
      chk({tag, "_intr"}, {31'd0, o_intr},   32'h0);
   endtask

   initial begin
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk_reset("reset");

      // Single capture and pop
      ctl_wr(8'h01);
      push(4'd3, 10'h2A5);
      chk("cap_hi",  {24'd0, o_rpt_hi}, 32'h32);
      chk("cap_lo",  {24'd0, o_rpt_lo}, 32'hA5);
      chk("cap_sta", {24'd0, o_rptsta}, 32'h01);
      pop();
      chk("pop_sta", {24'd0, o_rptsta}, 32'h40);
      chk("pop_hi",  {24'd0, o_rpt_hi}, 32'h00);
      chk("pop_lo",  {24'd0, o_rpt_lo}, 32'h00);
      pop();
      chk("pop_empty_sta", {24'd0, o_rptsta}, 32'h40);

      // Fill and overflow
      for (int i = 1; i <= 4; i++) push(4'd1, 10'(i));
      chk("full_sta", {24'd0, o_rptsta}, 32'h24);
      push(4'd1, 10'd5);
      chk("ovf_sta",  {24'd0, o_rptsta}, 32'hA4);
      chk("ovf_hi",   {24'd0, o_rpt_hi}, 32'h10);
      chk("ovf_head", {24'd0, o_rpt_lo}, 32'h01);
      ctl_wr(8'h81);
      chk("ovfc_sta", {24'd0, o_rptsta}, 32'h24);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain%0d", i), {24'd0, o_rpt_lo}, 32'(i));
         pop();
      end
      chk("drained_sta", {24'd0, o_rptsta}, 32'h40);

      // Push with pop while full, then while empty
      for (int i = 5; i <= 8; i++) push(4'd1, 10'(i));
      rpt_upd = 1'b1; rpt_ch = 4'd1; rpt_v = 10'd9; r_rd_lo = 1'b1;
      step();
      rpt_upd = 1'b0; r_rd_lo = 1'b0;
      chk("pp_full_sta", {24'd0, o_rptsta}, 32'h24);
      for (int i = 6; i <= 9; i++) begin
         chk($sformatf("pp_drain%0d", i), {24'd0, o_rpt_lo}, 32'(i));
         pop();
      end
      rpt_upd = 1'b1; rpt_ch = 4'd2; rpt_v = 10'h00C; r_rd_lo = 1'b1;
      step();
      rpt_upd = 1'b0; r_rd_lo = 1'b0;
      chk("pp_empty_sta", {24'd0, o_rptsta}, 32'h01);
      chk("pp_empty_lo",  {24'd0, o_rpt_lo}, 32'h0C);
      pop();

      // Mask and enable
      msk_wr(8'hFE);
      chk("msk_rd", {24'd0, o_rptmsk}, 32'hFE);
      push(4'd0, 10'h111);
      chk("msk_ch0_sta", {24'd0, o_rptsta}, 32'h40);
      push(4'd9, 10'h1C3);
      chk("msk_ch9_hi",  {24'd0, o_rpt_hi}, 32'h91);
      chk("msk_ch9_lo",  {24'd0, o_rpt_lo}, 32'hC3);
      chk("msk_ch9_sta", {24'd0, o_rptsta}, 32'h01);
      ctl_wr(8'h00);
      push(4'd9, 10'h0AA);
      chk("en0_sta", {24'd0, o_rptsta}, 32'h01);
      chk("en0_lo",  {24'd0, o_rpt_lo}, 32'hC3);
      pop();
      chk("en0_drain", {24'd0, o_rptsta}, 32'h40);
      msk_wr(8'hFF);

      // Interrupt threshold
      ctl_wr(8'h15);
      chk("thr2_idle", {31'd0, o_intr}, 32'h0);
      push(4'd4, 10'h001);
      chk("thr2_p1", {31'd0, o_intr}, 32'h0);
      chk("thr2_sta", {24'd0, o_rptsta}, 32'h11);
      push(4'd4, 10'h002);
      chk("thr2_p2", {31'd0, o_intr}, 32'h1);
      pop();
      chk("thr2_pop", {31'd0, o_intr}, 32'h0);
      pop();
      ctl_wr(8'h05);
      push(4'd4, 10'h003);
      chk("thr0_p1", {31'd0, o_intr}, 32'h1);
      ctl_wr(8'h3D);
      chk("thr7_c1", {31'd0, o_intr}, 32'h0);
      for (int i = 0; i < 2; i++) push(4'd4, 10'h004);
      chk("thr7_c3", {31'd0, o_intr}, 32'h0);
      push(4'd4, 10'h005);
      chk("thr7_c4", {31'd0, o_intr}, 32'h1);

      // clr against a simultaneous push
      push(4'd4, 10'h006);
      chk("pre_clr_sta", {24'd0, o_rptsta}, 32'hB4);
      r_wdat = 8'h07; r_wr = 2'b01; rpt_upd = 1'b1; rpt_ch = 4'd5; rpt_v = 10'h155;
      step();
      r_wr = 2'b00; rpt_upd = 1'b0;
      chk("clr_sta",  {24'd0, o_rptsta}, 32'h50);
      chk("clr_intr", {31'd0, o_intr},   32'h0);
      chk("clr_hi",   {24'd0, o_rpt_hi}, 32'h00);

      // Mid-run synchronous reset
      msk_wr(8'h3C);
      ctl_wr(8'h85);
      push(4'd2, 10'h3FF);
      push(4'd10, 10'h100);
      push(4'd11, 10'h200);
      chk("pre_srst_sta", {24'd0, o_rptsta}, 32'h13);
      srst = 1'b1; rpt_upd = 1'b1; rpt_ch = 4'd12; rpt_v = 10'h001; r_rd_lo = 1'b1;
      step();
      srst = 1'b0; rpt_upd = 1'b0; r_rd_lo = 1'b0;
      chk_reset("srst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
